// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle CPU controller: the state
// enum, opcode/funct encodings, ALU operation codes and datapath select codes.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_RESET_WAIT = 4'd0,
      S_FETCH      = 4'd1,
      S_DECODE     = 4'd2,
      S_MEM_ADDR   = 4'd3,
      S_MEM_READ   = 4'd4,
      S_MEM_WRITE  = 4'd5,
      S_MEM_WB     = 4'd6,
      S_R_EXEC     = 4'd7,
      S_R_WB       = 4'd8,
      S_I_EXEC     = 4'd9,
      S_I_WB       = 4'd10,
      S_BRANCH     = 4'd11,
      S_JUMP       = 4'd12,
      S_JAL        = 4'd13,
      S_JR         = 4'd14,
      S_ILLEGAL    = 4'd15
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_XOR = 3'd2,
      ALU_SLT = 3'd3
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_REG_A  = 2'd3;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   localparam logic [1:0] ALUB_REG_B   = 2'd0;
   localparam logic [1:0] ALUB_FOUR    = 2'd1;
   localparam logic [1:0] ALUB_IMM     = 2'd2;
   localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

endpackage

// File: rtl/multicycle_control_if.sv
// Handshake with the shared instruction/data memory. The controller is the
// master (drives request, write and address select), the memory is the slave.
interface multicycle_control_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output iord, input mem_ready);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_decode.sv
// Combinational instruction decode: the state that follows DECODE, and the
// ALU operation used by the R-type / I-type execute states.
module multicycle_decode
   import multicycle_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output state_t     next_state,
   output alu_op_t    exec_alu_op
);

   // Opcode/funct to next state; anything unrecognised lands in ILLEGAL.
   always_comb begin
      next_state  = S_ILLEGAL;
      exec_alu_op = ALU_ADD;
      case (opcode)
         OP_LW, OP_SW: next_state = S_MEM_ADDR;
         OP_RTYPE: begin
            case (funct)
               FN_ADD: next_state = S_R_EXEC;
               FN_SUB: begin
                  next_state  = S_R_EXEC;
                  exec_alu_op = ALU_SUB;
               end
               FN_SLT: begin
                  next_state  = S_R_EXEC;
                  exec_alu_op = ALU_SLT;
               end
               FN_JR:   next_state = S_JR;
               default: next_state = S_ILLEGAL;
            endcase
         end
         OP_ADDI: next_state = S_I_EXEC;
         OP_XORI: begin
            next_state  = S_I_EXEC;
            exec_alu_op = ALU_XOR;
         end
         OP_BEQ, OP_BNE: next_state = S_BRANCH;
         OP_J:           next_state = S_JUMP;
         OP_JAL:         next_state = S_JAL;
         default:        next_state = S_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU sequencing controller. Optional feature macro:
// MULTICYCLE_CTRL_TRAP_EN -- when defined, ILLEGAL raises trap and parks until
// reset; otherwise ILLEGAL is a one-cycle NOP and trap is tied low.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   RESET_WAIT | post-reset hold, RESET_PC_HOLD cycles, outputs 0
//   FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
//   DECODE     | branch target precompute into ALUOut
//   MEM_ADDR   | effective address = A + imm
//   MEM_READ   | load access at ALUOut
//   MEM_WRITE  | store access at ALUOut
//   MEM_WB     | MDR -> rt
//   R_EXEC     | A op B
//   R_WB       | ALUOut -> rd
//   I_EXEC     | A op imm
//   I_WB       | ALUOut -> rt
//   BRANCH     | compare A/B, conditional PC <= ALUOut
//   JUMP       | PC <= jump target
//   JAL        | PC <= jump target, $31 <= PC+4
//   JR         | PC <= A
//   ILLEGAL    | unrecognised instruction
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int RESET_PC_HOLD = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [5:0]                  opcode,
   input  logic [5:0]                  funct,
   input  logic                        zero,
   multicycle_control_if.master        mem,
   output logic                        ir_we,
   output logic                        pc_we,
   output logic [1:0]                  pc_src,
   output logic                        reg_we,
   output logic [1:0]                  reg_dst,
   output logic [1:0]                  mem_to_reg,
   output logic                        alu_src_a,
   output logic [1:0]                  alu_src_b,
   output logic [2:0]                  alu_op,
   output logic                        trap,
   output logic [3:0]                  state_dbg
);

   localparam logic [3:0] HOLD_LOAD = 4'(RESET_PC_HOLD - 1);

   state_t     state;
   state_t     dec_next;
   alu_op_t    exec_alu_op;
   logic [3:0] hold_cnt;
   logic       mem_req_c;
   logic       mem_we_c;
   logic       iord_c;

   multicycle_decode u_decode (
      .opcode      (opcode),
      .funct       (funct),
      .next_state  (dec_next),
      .exec_alu_op (exec_alu_op)
   );

   // State register plus the post-reset hold down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_RESET_WAIT;
         hold_cnt <= HOLD_LOAD;
      end else begin
         case (state)
            S_RESET_WAIT: begin
               if (hold_cnt == 4'd0) state <= S_FETCH;
               else                  hold_cnt <= hold_cnt - 4'd1;
            end
            S_FETCH:     if (mem.mem_ready) state <= S_DECODE;
            S_DECODE:    state <= dec_next;
            S_MEM_ADDR:  state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem.mem_ready) state <= S_MEM_WB;
            S_MEM_WRITE: if (mem.mem_ready) state <= S_FETCH;
            S_R_EXEC:    state <= S_R_WB;
            S_I_EXEC:    state <= S_I_WB;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_ILLEGAL:   state <= S_ILLEGAL;
`else
            S_ILLEGAL:   state <= S_FETCH;
`endif
            default:     state <= S_FETCH;
         endcase
      end
   end

   // Datapath controls: Moore decode of state, qualified by mem_ready in FETCH
   // and by zero/opcode in BRANCH.
   always_comb begin
      mem_req_c  = 1'b0;
      mem_we_c   = 1'b0;
      iord_c     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_ALU;
      reg_we     = 1'b0;
      reg_dst    = REG_DST_RT;
      mem_to_reg = WB_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = ALUB_REG_B;
      alu_op     = ALU_ADD;
      trap       = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req_c = 1'b1;
            alu_src_b = ALUB_FOUR;
            ir_we     = mem.mem_ready;
            pc_we     = mem.mem_ready;
         end
         S_DECODE:   alu_src_b = ALUB_IMM_SH2;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
         end
         S_MEM_READ: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
            iord_c    = 1'b1;
         end
         S_MEM_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = WB_MDR;
         end
         S_R_EXEC, S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = (state == S_I_EXEC) ? ALUB_IMM : ALUB_REG_B;
            alu_op    = exec_alu_op;
         end
         S_R_WB: begin
            reg_we  = 1'b1;
            reg_dst = REG_DST_RD;
         end
         S_I_WB: reg_we = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = PC_SRC_ALUOUT;
            pc_we     = (opcode == OP_BNE) ? !zero : zero;
         end
         S_JUMP: begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_JUMP;
         end
         S_JAL: begin
            pc_we      = 1'b1;
            pc_src     = PC_SRC_JUMP;
            reg_we     = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = WB_PC;
         end
         S_JR: begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_REG_A;
         end
`ifdef MULTICYCLE_CTRL_TRAP_EN
         S_ILLEGAL: trap = 1'b1;
`endif
         default: ;
      endcase
   end

   assign mem.mem_req = mem_req_c;
   assign mem.mem_we  = mem_we_c;
   assign mem.iord    = iord_c;
   assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded into
// the expected per-cycle output sequence from the instruction-class rules,
// including memory wait cycles, and compared against the DUT every cycle.
module tb_multicycle_control;
   import multicycle_pkg::*;

   localparam int HOLD = 3;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       trap;
      logic [3:0] state;
   } outs_t;

   typedef struct {
      logic  ready;
      outs_t o;
   } cyc_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       ir_we, pc_we, reg_we, alu_src_a, trap;
   logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
   logic [2:0] alu_op;
   logic [3:0] state_dbg;
   outs_t      obs;

   int n_checks = 0;
   int n_fail   = 0;
   cyc_t plan[$];

   multicycle_control_if bus ();

   multicycle_control #(.RESET_PC_HOLD(HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem        (bus),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .reg_we     (reg_we),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .trap       (trap),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   assign obs = {bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we, pc_src, reg_we,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, trap, state_dbg};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic outs_t idle(input state_t s);
      outs_t o;
      o = '0;
      o.state = 4'(s);
      return o;
   endfunction

   task automatic add(input logic rdy, input outs_t o);
      cyc_t c;
      c.ready = rdy;
      c.o     = o;
      plan.push_back(c);
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected cycle sequence for one instruction.
   task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int w_fetch, input int w_mem);
      outs_t o;
      o = idle(S_FETCH);
      o.mem_req = 1'b1;
      o.alu_src_b = 2'd1;
      for (int i = 0; i < w_fetch; i++) add(1'b0, o);
      o.ir_we = 1'b1;
      o.pc_we = 1'b1;
      add(1'b1, o);
      o = idle(S_DECODE);
      o.alu_src_b = 2'd3;
      add(rnd_bit(), o);
      if (op == 6'h23 || op == 6'h2B) begin
         o = idle(S_MEM_ADDR);
         o.alu_src_a = 1'b1;
         o.alu_src_b = 2'd2;
         add(rnd_bit(), o);
         o = idle(op == 6'h23 ? S_MEM_READ : S_MEM_WRITE);
         o.mem_req = 1'b1;
         o.iord    = 1'b1;
         o.mem_we  = (op == 6'h2B);
         for (int i = 0; i < w_mem; i++) add(1'b0, o);
         add(1'b1, o);
         if (op == 6'h23) begin
            o = idle(S_MEM_WB);
            o.reg_we = 1'b1;
            o.mem_to_reg = 2'd1;
            add(rnd_bit(), o);
         end
      end else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
         o = idle(S_R_EXEC);
         o.alu_src_a = 1'b1;
         o.alu_op = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 : 3'd3;
         add(rnd_bit(), o);
         o = idle(S_R_WB);
         o.reg_we = 1'b1;
         o.reg_dst = 2'd1;
         add(rnd_bit(), o);
      end else if (op == 6'h00 && fn == 6'h08) begin
         o = idle(S_JR);
         o.pc_we = 1'b1;
         o.pc_src = 2'd3;
         add(rnd_bit(), o);
      end else if (op == 6'h08 || op == 6'h0E) begin
         o = idle(S_I_EXEC);
         o.alu_src_a = 1'b1;
         o.alu_src_b = 2'd2;
         o.alu_op = (op == 6'h0E) ? 3'd2 : 3'd0;
         add(rnd_bit(), o);
         o = idle(S_I_WB);
         o.reg_we = 1'b1;
         add(rnd_bit(), o);
      end else if (op == 6'h04 || op == 6'h05) begin
         o = idle(S_BRANCH);
         o.alu_src_a = 1'b1;
         o.alu_op = 3'd1;
         o.pc_src = 2'd1;
         o.pc_we = (op == 6'h04) ? z : !z;
         add(rnd_bit(), o);
      end else if (op == 6'h02 || op == 6'h03) begin
         o = idle(op == 6'h02 ? S_JUMP : S_JAL);
         o.pc_we = 1'b1;
         o.pc_src = 2'd2;
         if (op == 6'h03) begin
            o.reg_we = 1'b1;
            o.reg_dst = 2'd2;
            o.mem_to_reg = 2'd2;
         end
         add(rnd_bit(), o);
      end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
         o = idle(S_ILLEGAL);
         o.trap = 1'b1;
         for (int i = 0; i < 10; i++) add(rnd_bit(), o);
`else
         add(rnd_bit(), idle(S_ILLEGAL));
`endif
      end
   endtask

   // Runs up to max_cyc planned cycles; entered and left at posedge+1.
   task automatic run_plan(input string tag, input int max_cyc);
      cyc_t c;
      int   n;
      n = 0;
      while (plan.size() > 0 && n < max_cyc) begin
         c = plan.pop_front();
         bus.mem_ready = c.ready;
         #3;
         check_eq($sformatf("%s cyc%0d", tag, n), 32'(obs), 32'(c.o));
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int w_fetch, input int w_mem);
      opcode = op;
      funct  = fn;
      zero   = z;
      plan_instr(op, fn, z, w_fetch, w_mem);
      run_plan(tag, 1000);
   endtask

   // Hold reset across two edges (entered at posedge+1), then release and
   // check the RESET_WAIT window with mem_ready high.
   task automatic reset_release(input string tag);
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      check_eq({tag, " in_reset"}, 32'(obs), 32'(idle(S_RESET_WAIT)));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      plan.delete();
      for (int i = 0; i < HOLD; i++) add(1'b1, idle(S_RESET_WAIT));
      run_plan({tag, " reset_wait"}, HOLD);
   endtask

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A || fn == 6'h08);
      return (op == 6'h23 || op == 6'h2B || op == 6'h08 || op == 6'h0E ||
              op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h03);
   endfunction

   initial begin
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      reset_release("por");

      run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0);
      run_instr("lw_wait2", 6'h23, 6'h00, 1'b0, 0, 2);
      run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
      run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
      run_instr("jal", 6'h03, 6'h00, 1'b0, 0, 0);

      // Randomised instruction stream with random memory waits.
      for (int k = 0; k < 250; k++) begin
         logic [5:0] op, fn;
         int sel;
         sel = int'($urandom_range(0, 13));
         fn = 6'($urandom);
         case (sel)
            0: begin op = 6'h00; fn = 6'h20; end
            1: begin op = 6'h00; fn = 6'h22; end
            2: begin op = 6'h00; fn = 6'h2A; end
            3: begin op = 6'h00; fn = 6'h08; end
            4: op = 6'h23;
            5: op = 6'h2B;
            6: op = 6'h08;
            7: op = 6'h0E;
            8: op = 6'h04;
            9: op = 6'h05;
            10: op = 6'h02;
            11: op = 6'h03;
            default: op = 6'($urandom);
         endcase
`ifdef MULTICYCLE_CTRL_TRAP_EN
         if (!is_legal(op, fn)) begin
            op = 6'h00;
            fn = 6'h20;
         end
`endif
         run_instr($sformatf("rnd%0d op%02h fn%02h", k, op, fn), op, fn, rnd_bit(),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      // Illegal opcode 0x3F.
      run_instr("illegal", 6'h3F, 6'h00, 1'b0, 0, 0);
`ifdef MULTICYCLE_CTRL_TRAP_EN
      reset_release("trap_exit");
`endif
      run_instr("after_illegal", 6'h00, 6'h22, 1'b0, 0, 0);

      // Reset pulsed during a stalled store.
      opcode = 6'h2B;
      funct  = 6'h00;
      plan_instr(6'h2B, 6'h00, 1'b0, 0, 5);
      run_plan("sw_stall", 5);
      bus.mem_ready = 1'b0;
      #3;
      check_eq("sw_mid_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd3);
      rst_n = 1'b0;
      #1;
      check_eq("sw_abort_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
      check_eq("sw_abort_state", 32'(state_dbg), 32'd0);
      @(posedge clk);
      #1;
      reset_release("sw_abort");
      run_instr("post_abort_xori", 6'h0E, 6'h00, 1'b0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
